// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multi-cycle MIPS controller (master) and its datapath (slave).
interface multicycle_ctrl_fsm_if;
  logic [5:0] Op;
  logic       Zero;
  logic       MemReady;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       ExtOp;
  logic [1:0] PCSrc;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       Illegal;
  logic       MemFault;

  modport master (
    input  Op, Zero, MemReady,
    output IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, ExtOp, PCSrc, PCWrite, PCWriteCond,
           Illegal, MemFault
  );

  modport slave (
    output Op, Zero, MemReady,
    input  IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, ExtOp, PCSrc, PCWrite, PCWriteCond,
           Illegal, MemFault
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle MIPS datapath, with a MemReady timeout watchdog.
// Optional lui support is enabled by defining CTRL_LUI_EN.
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  multicycle_ctrl_fsm_if.master bus
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ORIEX  = 4'd10;
  localparam logic [3:0] S_IMMWB  = 4'd11;
  localparam logic [3:0] S_JUMP   = 4'd12;
  localparam logic [3:0] S_HALT   = 4'd13;
`ifdef CTRL_LUI_EN
  localparam logic [3:0] S_LUIEX  = 4'd14;
`endif

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef struct packed {
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       ExtOp;
    logic [1:0] PCSrc;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       Illegal;
    logic       MemFault;
  } ctl_t;

  logic [3:0]       state_q, state_nxt;
  logic [CNT_W-1:0] wait_q, wait_nxt;
  logic             fault_q, fault_nxt;
  logic             ext_q;
  logic             mem_wait, timeout, illegal_op;
  ctl_t             ctl, ctl_out;

  // A memory-wait cycle is any cycle in an access state without MemReady; MemReady resets the count.
  assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR)) &&
                    !bus.MemReady;
  assign timeout  = mem_wait && (wait_q == TIMEOUT_LAST);

  always_comb begin
    state_nxt  = state_q;
    fault_nxt  = fault_q;
    illegal_op = 1'b0;
    wait_nxt   = mem_wait ? (wait_q + CNT_W'(1)) : '0;
    case (state_q)
      S_FETCH:  if (bus.MemReady) state_nxt = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_ORI:       state_nxt = S_ORIEX;
          OP_J:         state_nxt = S_JUMP;
`ifdef CTRL_LUI_EN
          OP_LUI:       state_nxt = S_LUIEX;
`endif
          default: begin
            illegal_op = 1'b1;
            state_nxt  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: state_nxt = (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.MemReady) state_nxt = S_MEMWB;
      S_MEMWR:  if (bus.MemReady) state_nxt = S_FETCH;
      S_EXEC:   state_nxt = S_ALUWB;
      S_ADDIEX: state_nxt = S_IMMWB;
      S_ORIEX:  state_nxt = S_IMMWB;
`ifdef CTRL_LUI_EN
      S_LUIEX:  state_nxt = S_IMMWB;
`endif
      S_MEMWB, S_ALUWB, S_BRANCH, S_IMMWB, S_JUMP: state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
    if (timeout) begin
      state_nxt = S_HALT;
      fault_nxt = 1'b1;
      wait_nxt  = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      fault_q <= 1'b0;
      ext_q   <= 1'b1;
    end else begin
      state_q <= state_nxt;
      wait_q  <= wait_nxt;
      fault_q <= fault_nxt;
      ext_q   <= ctl.ExtOp;
    end
  end

  // Illegal is decoded during DECODE from the IR opcode, so it pulses in the cycle before FETCH.
  always_comb begin
    ctl          = '0;
    ctl.ExtOp    = 1'b1;
    ctl.MemFault = fault_q;
    ctl.Illegal  = illegal_op;
    case (state_q)
      S_FETCH: begin
        ctl.MemRead = 1'b1;
        ctl.ALUSrcB = 2'b01;
        ctl.IRWrite = bus.MemReady;
        ctl.PCWrite = bus.MemReady;
      end
      S_DECODE: ctl.ALUSrcB = 2'b11;
      S_MEMADR: begin
        ctl.ALUSrcA = 1'b1;
        ctl.ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        ctl.IorD    = 1'b1;
        ctl.MemRead = 1'b1;
      end
      S_MEMWB: begin
        ctl.MemtoReg = 1'b1;
        ctl.RegWrite = 1'b1;
      end
      S_MEMWR: begin
        ctl.IorD     = 1'b1;
        ctl.MemWrite = 1'b1;
      end
      S_EXEC: begin
        ctl.ALUSrcA = 1'b1;
        ctl.ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        ctl.RegDst   = 1'b1;
        ctl.RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ctl.ALUSrcA     = 1'b1;
        ctl.ALUOp       = 2'b01;
        ctl.PCSrc       = 2'b01;
        ctl.PCWriteCond = 1'b1;
      end
      S_ADDIEX: begin
        ctl.ALUSrcA = 1'b1;
        ctl.ALUSrcB = 2'b10;
      end
      S_ORIEX: begin
        ctl.ALUSrcA = 1'b1;
        ctl.ALUSrcB = 2'b10;
        ctl.ALUOp   = 2'b11;
        ctl.ExtOp   = 1'b0;
      end
`ifdef CTRL_LUI_EN
      S_LUIEX: begin
        ctl.ALUSrcB = 2'b10;
        ctl.ExtOp   = 1'b0;
      end
`endif
      // Write-back keeps the extension mode of the execute step so the immediate stays stable.
      S_IMMWB: begin
        ctl.RegWrite = 1'b1;
        ctl.ExtOp    = ext_q;
      end
      S_JUMP: begin
        ctl.PCSrc   = 2'b10;
        ctl.PCWrite = 1'b1;
      end
      S_HALT:  ctl.ExtOp = 1'b0;
      default: ctl.ExtOp = 1'b1;
    endcase
  end

  assign ctl_out = Rst ? '0 : ctl;

  assign bus.IorD        = ctl_out.IorD;
  assign bus.MemRead     = ctl_out.MemRead;
  assign bus.MemWrite    = ctl_out.MemWrite;
  assign bus.IRWrite     = ctl_out.IRWrite;
  assign bus.RegDst      = ctl_out.RegDst;
  assign bus.MemtoReg    = ctl_out.MemtoReg;
  assign bus.RegWrite    = ctl_out.RegWrite;
  assign bus.ALUSrcA     = ctl_out.ALUSrcA;
  assign bus.ALUSrcB     = ctl_out.ALUSrcB;
  assign bus.ALUOp       = ctl_out.ALUOp;
  assign bus.ExtOp       = ctl_out.ExtOp;
  assign bus.PCSrc       = ctl_out.PCSrc;
  assign bus.PCWrite     = ctl_out.PCWrite;
  assign bus.PCWriteCond = ctl_out.PCWriteCond;
  assign bus.Illegal     = ctl_out.Illegal;
  assign bus.MemFault    = ctl_out.MemFault;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench for multicycle_ctrl_fsm: an instruction-step model predicts every output each cycle,
// plus directed literal checks for reset, lw, beq, ori/addi, timeout and opcode 0F.
module tb_multicycle_ctrl_fsm;
  localparam int MEM_TIMEOUT = 15;
`ifdef CTRL_LUI_EN
  localparam bit LUI_EN = 1'b1;
`else
  localparam bit LUI_EN = 1'b0;
`endif

  // Instruction steps as named by the control description.
  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MWR = 5, EX = 6, AWB = 7;
  localparam int BR = 8, AI = 9, OI = 10, IWB = 11, J = 12, H = 13, LU = 14;

  typedef struct packed {
    logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       ExtOp;
    logic [1:0] PCSrc;
    logic       PCWrite, PCWriteCond, Illegal, MemFault;
  } ctl_t;

  logic Clk;
  logic rst;
  multicycle_ctrl_fsm_if bus ();

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(8)) dut (
    .Clk(Clk),
    .Rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  int         m_step = F;
  int         m_wait = 0;
  bit         m_fault = 1'b0;
  logic [5:0] m_iop = 6'h00;
  int         m_plan[$];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic bit op_legal(input logic [5:0] o);
    return (o == 6'h23) || (o == 6'h2B) || (o == 6'h00) || (o == 6'h04) || (o == 6'h08) ||
           (o == 6'h0D) || (o == 6'h02) || (LUI_EN && (o == 6'h0F));
  endfunction

  function automatic ctl_t expect_ctl(input int s, input bit r, input logic [5:0] o, input bit rdy,
                                      input bit flt, input logic [5:0] iop);
    ctl_t e;
    e = '0;
    if (r) return e;
    e.ExtOp = 1'b1;
    case (s)
      F:   begin e.MemRead = 1; e.ALUSrcB = 2'b01; e.IRWrite = rdy; e.PCWrite = rdy; end
      D:   begin e.ALUSrcB = 2'b11; e.Illegal = !op_legal(o); end
      MA:  begin e.ALUSrcA = 1; e.ALUSrcB = 2'b10; end
      MR:  begin e.IorD = 1; e.MemRead = 1; end
      MWB: begin e.MemtoReg = 1; e.RegWrite = 1; end
      MWR: begin e.IorD = 1; e.MemWrite = 1; end
      EX:  begin e.ALUSrcA = 1; e.ALUOp = 2'b10; end
      AWB: begin e.RegDst = 1; e.RegWrite = 1; end
      BR:  begin e.ALUSrcA = 1; e.ALUOp = 2'b01; e.PCSrc = 2'b01; e.PCWriteCond = 1; end
      AI:  begin e.ALUSrcA = 1; e.ALUSrcB = 2'b10; end
      OI:  begin e.ALUSrcA = 1; e.ALUSrcB = 2'b10; e.ALUOp = 2'b11; e.ExtOp = 0; end
      LU:  begin e.ALUSrcB = 2'b10; e.ExtOp = 0; end
      IWB: begin e.RegWrite = 1; e.ExtOp = !((iop == 6'h0D) || (LUI_EN && iop == 6'h0F)); end
      J:   begin e.PCSrc = 2'b10; e.PCWrite = 1; end
      H:   e.ExtOp = 0;
      default: e = '0;
    endcase
    e.MemFault = flt;
    return e;
  endfunction

  function automatic ctl_t dut_ctl();
    ctl_t a;
    a.IorD = bus.IorD;         a.MemRead = bus.MemRead;   a.MemWrite = bus.MemWrite;
    a.IRWrite = bus.IRWrite;   a.RegDst = bus.RegDst;     a.MemtoReg = bus.MemtoReg;
    a.RegWrite = bus.RegWrite; a.ALUSrcA = bus.ALUSrcA;   a.ALUSrcB = bus.ALUSrcB;
    a.ALUOp = bus.ALUOp;       a.ExtOp = bus.ExtOp;       a.PCSrc = bus.PCSrc;
    a.PCWrite = bus.PCWrite;   a.PCWriteCond = bus.PCWriteCond;
    a.Illegal = bus.Illegal;   a.MemFault = bus.MemFault;
    return a;
  endfunction

  // Model: each instruction is a list of steps chosen at decode; memory steps stall until MemReady.
  initial begin
    forever begin
      @(posedge Clk);
      if (rst) begin
        m_step = F; m_wait = 0; m_fault = 1'b0; m_plan.delete();
      end else if (m_step == H) begin
        m_step = H;
      end else if ((m_step == F || m_step == MR || m_step == MWR) && !bus.MemReady) begin
        m_wait++;
        if (m_wait >= MEM_TIMEOUT) begin
          m_fault = 1'b1; m_step = H; m_wait = 0; m_plan.delete();
        end
      end else begin
        m_wait = 0;
        if (m_step == F) begin
          m_step = D;
        end else begin
          if (m_step == D) begin
            m_iop = bus.Op;
            m_plan.delete();
            case (bus.Op)
              6'h23: m_plan = '{MA, MR, MWB};
              6'h2B: m_plan = '{MA, MWR};
              6'h00: m_plan = '{EX, AWB};
              6'h04: m_plan = '{BR};
              6'h08: m_plan = '{AI, IWB};
              6'h0D: m_plan = '{OI, IWB};
              6'h02: m_plan = '{J};
              6'h0F: if (LUI_EN) m_plan = '{LU, IWB};
              default: m_plan.delete();
            endcase
          end
          if (m_plan.size() > 0) m_step = m_plan.pop_front();
          else m_step = F;
        end
      end
    end
  end

  initial begin
    ctl_t e, a;
    forever begin
      @(negedge Clk);
      e = expect_ctl(m_step, rst, bus.Op, bus.MemReady, m_fault, m_iop);
      a = dut_ctl();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_compare t=%0t step=%0d rst=%0b op=%h rdy=%0b got=%h want=%h",
                 $time, m_step, rst, bus.Op, bus.MemReady, a, e);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic cyc(input bit r, input logic [5:0] o, input bit rdy, input bit z);
    @(posedge Clk);
    #1;
    rst = r; bus.Op = o; bus.MemReady = rdy; bus.Zero = z;
    @(negedge Clk);
  endtask

  initial begin
    logic [5:0] ops [8];
    int n;
    bit slow;
    logic [5:0] cur_op;
    ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h0D, 6'h02, 6'h0F};
    rst = 1'b1; bus.Op = 6'h00; bus.MemReady = 1'b0; bus.Zero = 1'b0;

    cyc(1, 6'h00, 0, 0);
    cyc(1, 6'h00, 0, 0);
    lit("reset_all_zero", 32'(dut_ctl()), 32'h0);

    cyc(0, 6'h23, 1, 0);
    lit("first_fetch_memread_irwrite", {bus.MemRead, bus.IRWrite, bus.IorD}, 3'b110);
    repeat (3) cyc(0, 6'h23, 1, 0);
    cyc(0, 6'h23, 1, 0);
    lit("lw_cycle5_regwrite_memtoreg", {bus.RegWrite, bus.MemtoReg, bus.RegDst}, 3'b110);

    repeat (3) cyc(0, 6'h04, 1, 1);
    lit("beq_z1_pcwritecond_pcsrc", {bus.PCWriteCond, bus.PCSrc, bus.PCWrite}, 4'b1010);
    repeat (3) cyc(0, 6'h04, 1, 0);
    lit("beq_z0_pcwritecond_pcsrc", {bus.PCWriteCond, bus.PCSrc, bus.PCWrite}, 4'b1010);

    repeat (3) cyc(0, 6'h0D, 1, 0);
    lit("ori_exec_extop", {bus.ExtOp, bus.ALUOp}, 3'b011);
    cyc(0, 6'h0D, 1, 0);
    lit("ori_wb_extop", {bus.RegWrite, bus.ExtOp}, 2'b10);
    repeat (3) cyc(0, 6'h08, 1, 0);
    lit("addi_exec_extop", {bus.ExtOp, bus.ALUSrcB}, 3'b110);
    cyc(0, 6'h08, 1, 0);

    n = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 6'h00, 0, 0);
      if (bus.MemFault) break;
      n++;
    end
    lit("timeout_wait_cycles", n, MEM_TIMEOUT);
    lit("halt_outputs", 32'(dut_ctl()), 32'h1);
    cyc(0, 6'h00, 1, 0);
    lit("halt_sticky", {bus.MemFault, bus.MemRead}, 2'b10);
    cyc(1, 6'h00, 0, 0);
    lit("reset_clears_fault", bus.MemFault, 1'b0);
    repeat (14) cyc(0, 6'h00, 0, 0);
    cyc(0, 6'h00, 1, 0);
    lit("ready_on_last_cycle_no_fault", {bus.MemFault, bus.IRWrite}, 2'b01);
    cyc(0, 6'h00, 0, 0);
    lit("ready_on_last_cycle_decode", {bus.MemFault, bus.ALUSrcB}, 3'b011);
    repeat (2) cyc(0, 6'h00, 0, 0);

    cyc(0, 6'h0F, 1, 0);
    cyc(0, 6'h0F, 1, 0);
`ifdef CTRL_LUI_EN
    lit("op0f_decode_no_illegal", bus.Illegal, 1'b0);
    cyc(0, 6'h0F, 1, 0);
    cyc(0, 6'h0F, 1, 0);
    lit("lui_cycle4_regwrite", {bus.RegWrite, bus.ExtOp}, 2'b10);
`else
    lit("op0f_illegal_pulse", bus.Illegal, 1'b1);
    cyc(0, 6'h0F, 1, 0);
    lit("op0f_back_to_fetch", {bus.Illegal, bus.MemRead}, 2'b01);
`endif

    cur_op = 6'h00;
    for (int i = 0; i < 4000; i++) begin
      @(posedge Clk);
      #1;
      slow = ((i / 250) % 4) == 3;
      rst = (m_step == H) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 299) == 0);
      bus.MemReady = slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) != 0);
      bus.Zero = $urandom_range(0, 1);
      if (m_step == F) begin
        n = $urandom_range(0, 8);
        cur_op = (n == 8) ? 6'($urandom_range(0, 63)) : ops[n];
      end
      bus.Op = cur_op;
      @(negedge Clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
